// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle control unit: state encoding,
// instruction opcodes/functs, ALU operation codes and the control bundle.
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_e;

   // Primary opcodes (instruction[31:26])
   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_JAL  = 6'h03;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;

   // R-type function codes (instruction[5:0])
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   // ALU operation codes
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;
   localparam logic [3:0] ALU_SLTU = 4'd10;

   // Next-PC source selects
   localparam logic [1:0] PC_PLUS1  = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;
   localparam logic [1:0] PC_RS     = 2'd3;

   // Datapath control bundle produced each cycle
   typedef struct packed {
      logic       pc_we;
      logic       ir_we;
      logic       reg_we;
      logic       mem_rd;
      logic       mem_wr;
      logic       alu_src;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       link;
      logic [1:0] pc_sel;
      logic [3:0] alu_op;
      logic       halted;
   } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Maps an R-type funct field onto the ALU operation code.
module alu_decoder
   import multicycle_ctrl_pkg::*;
(
   input  logic [5:0] funct,
   output logic [3:0] alu_op
);

   // Funct lookup; unknown functs fall back to ADD
   always_comb begin
      alu_op = ALU_ADD;
      case (funct)
         FN_SLL:  alu_op = ALU_SLL;
         FN_SRL:  alu_op = ALU_SRL;
         FN_SRA:  alu_op = ALU_SRA;
         FN_ADD:  alu_op = ALU_ADD;
         FN_ADDU: alu_op = ALU_ADD;
         FN_SUB:  alu_op = ALU_SUB;
         FN_SUBU: alu_op = ALU_SUB;
         FN_AND:  alu_op = ALU_AND;
         FN_OR:   alu_op = ALU_OR;
         FN_XOR:  alu_op = ALU_XOR;
         FN_NOR:  alu_op = ALU_NOR;
         FN_SLT:  alu_op = ALU_SLT;
         FN_SLTU: alu_op = ALU_SLTU;
         default: alu_op = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control unit: instruction sequencing FSM, datapath
// control decode, sticky illegal-opcode flag and retired-instruction counter.
// Control outputs are decoded combinationally from the current state and the
// instruction fields held in the instruction register.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int RET_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             dm_ready,
   input  logic             halt_req,
   output logic             pc_we,
   output logic             ir_we,
   output logic             reg_we,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             alu_src,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             link,
   output logic [1:0]       pc_sel,
   output logic [3:0]       alu_op,
   output logic             halted,
   output logic             illegal,
   output logic [RET_W-1:0] retired,
   output logic [2:0]       state
);

   state_e             state_q, state_d;
   logic [RET_W-1:0]   retired_q, retired_d;
   logic               illegal_q, illegal_d;
   logic               retire;
   logic               is_r, is_jr;
   logic [3:0]         r_alu_op;
   ctrl_t              ctrl_raw;
   ctrl_t              ctrl_out;

   alu_decoder u_alu_decoder (
      .funct  (funct),
      .alu_op (r_alu_op)
   );

   // Instruction class, next state, retire strobe and control decode
   always_comb begin
      ctrl_raw  = '0;
      state_d   = state_q;
      illegal_d = illegal_q;
      retire    = 1'b0;
      is_r      = (opcode == OP_R) && (funct != FN_JR);
      is_jr     = (opcode == OP_R) && (funct == FN_JR);

      case (state_q)
         S_FETCH: begin
            // halt_req only takes effect at an instruction boundary
            if (halt_req) begin
               state_d = S_HALT;
            end else begin
               ctrl_raw.ir_we  = 1'b1;
               ctrl_raw.pc_we  = 1'b1;
               ctrl_raw.pc_sel = PC_PLUS1;
               state_d         = S_DECODE;
            end
         end
         S_DECODE: begin
            if (is_r || (opcode inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE})) begin
               state_d = S_EXEC;
            end else if (opcode == OP_J || opcode == OP_JAL) begin
               ctrl_raw.pc_we  = 1'b1;
               ctrl_raw.pc_sel = PC_JUMP;
               ctrl_raw.reg_we = (opcode == OP_JAL);
               ctrl_raw.link   = (opcode == OP_JAL);
               retire          = 1'b1;
               state_d         = S_FETCH;
            end else if (is_jr) begin
               ctrl_raw.pc_we  = 1'b1;
               ctrl_raw.pc_sel = PC_RS;
               retire          = 1'b1;
               state_d         = S_FETCH;
            end else begin
               illegal_d = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_EXEC: begin
            if (is_r) begin
               ctrl_raw.reg_dst = 1'b1;
               ctrl_raw.alu_op  = r_alu_op;
               state_d          = S_WB;
            end else if (opcode == OP_ADDI) begin
               ctrl_raw.alu_src = 1'b1;
               ctrl_raw.alu_op  = ALU_ADD;
               state_d          = S_WB;
            end else if (opcode == OP_LW || opcode == OP_SW) begin
               ctrl_raw.alu_src = 1'b1;
               ctrl_raw.alu_op  = ALU_ADD;
               state_d          = S_MEM;
            end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
               ctrl_raw.alu_op = ALU_SUB;
               ctrl_raw.pc_sel = PC_BRANCH;
               ctrl_raw.pc_we  = zero ^ (opcode == OP_BNE);
               retire          = 1'b1;
               state_d         = S_FETCH;
            end else begin
               // Instruction register changed under us; restart cleanly
               state_d = S_FETCH;
            end
         end
         S_MEM: begin
            // Access strobe is held until the memory reports completion
            if (opcode == OP_LW) begin
               ctrl_raw.mem_rd = 1'b1;
               if (dm_ready) state_d = S_WB;
            end else if (opcode == OP_SW) begin
               ctrl_raw.mem_wr = 1'b1;
               if (dm_ready) begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
            end else begin
               state_d = S_FETCH;
            end
         end
         S_WB: begin
            ctrl_raw.reg_we     = 1'b1;
            ctrl_raw.mem_to_reg = (opcode == OP_LW);
            retire              = 1'b1;
            state_d             = S_FETCH;
         end
         S_HALT: begin
            ctrl_raw.halted = 1'b1;
            // An illegal-opcode stop is only cleared by reset
            if (!halt_req && !illegal_q) state_d = S_FETCH;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      retired_d = retire ? retired_q + RET_W'(1) : retired_q;
   end

   // State, sticky illegal flag and retire counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
         illegal_q <= illegal_d;
      end
   end

   // All datapath controls are forced inactive while reset is asserted
   always_comb begin
      ctrl_out = rst ? ctrl_raw : '0;
   end

   assign pc_we      = ctrl_out.pc_we;
   assign ir_we      = ctrl_out.ir_we;
   assign reg_we     = ctrl_out.reg_we;
   assign mem_rd     = ctrl_out.mem_rd;
   assign mem_wr     = ctrl_out.mem_wr;
   assign alu_src    = ctrl_out.alu_src;
   assign reg_dst    = ctrl_out.reg_dst;
   assign mem_to_reg = ctrl_out.mem_to_reg;
   assign link       = ctrl_out.link;
   assign pc_sel     = ctrl_out.pc_sel;
   assign alu_op     = ctrl_out.alu_op;
   assign halted     = ctrl_out.halted;
   assign illegal    = illegal_q;
   assign retired    = retired_q;
   assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction cycle traces built from the
// instruction timing rules, compared against the DUT every cycle.
module tb_multicycle_ctrl;
   import multicycle_ctrl_pkg::*;

   localparam int RET_W = 8;

   typedef struct packed {
      logic [2:0]       st;
      logic             pc_we, ir_we, reg_we, mem_rd, mem_wr;
      logic             alu_src, reg_dst, mem_to_reg, link;
      logic [1:0]       pc_sel;
      logic [3:0]       alu_op;
      logic             halted, illegal;
      logic [RET_W-1:0] ret;
   } obs_t;

   localparam int OBS_W = $bits(obs_t);

   localparam int NFN = 13;
   localparam logic [5:0] FN_TAB [NFN] = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22,
                                           6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
   localparam logic [3:0] AL_TAB [NFN] = '{ALU_SLL, ALU_SRL, ALU_SRA, ALU_ADD, ALU_ADD, ALU_SUB,
                                           ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU};

   // clock / reset / DUT
   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [5:0]       opcode = '0, funct = '0;
   logic             zero = 1'b0, dm_ready = 1'b0, halt_req = 1'b0;
   logic             pc_we, ir_we, reg_we, mem_rd, mem_wr, alu_src, reg_dst, mem_to_reg, link;
   logic [1:0]       pc_sel;
   logic [3:0]       alu_op;
   logic             halted, illegal;
   logic [RET_W-1:0] retired;
   logic [2:0]       state;

   always #5 clk = ~clk;

   multicycle_ctrl #(.RET_W(RET_W)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .dm_ready(dm_ready), .halt_req(halt_req), .pc_we(pc_we), .ir_we(ir_we),
      .reg_we(reg_we), .mem_rd(mem_rd), .mem_wr(mem_wr), .alu_src(alu_src),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .link(link), .pc_sel(pc_sel),
      .alu_op(alu_op), .halted(halted), .illegal(illegal), .retired(retired),
      .state(state)
   );

   // model state and scoreboard
   logic [OBS_W-1:0] exp_q[$];
   logic [RET_W-1:0] ret_m = '0;
   logic             ill_m = 1'b0;
   int               n_vec = 0;
   int               n_err = 0;
   int               steps = 0;
   int               t0;

   obs_t act_o;
   always_comb begin
      act_o = '{st: state, pc_we: pc_we, ir_we: ir_we, reg_we: reg_we, mem_rd: mem_rd,
                mem_wr: mem_wr, alu_src: alu_src, reg_dst: reg_dst, mem_to_reg: mem_to_reg,
                link: link, pc_sel: pc_sel, alu_op: alu_op, halted: halted,
                illegal: illegal, ret: retired};
   end

   // compare process: one expected observation per clock
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         obs_t e;
         e = obs_t'(exp_q.pop_front());
         n_vec++;
         if (act_o !== e) begin
            n_err++;
            $display("FAIL outputs @%0t: got %h required %h (state got %0d required %0d)",
                     $time, act_o, e, act_o.st, e.st);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   function automatic obs_t base(input logic [2:0] st);
      obs_t e;
      e = '0;
      e.st = st;
      e.illegal = ill_m;
      e.ret = ret_m;
      return e;
   endfunction

   function automatic logic hv(input int m);
      if (m == 2) return 1'b1;
      if (m == 1) return 1'($urandom_range(0, 1));
      return 1'b0;
   endfunction

   function automatic logic is_legal(input logic [5:0] op);
      return op inside {OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW};
   endfunction

   // driver: called at posedge+1 with inputs set for this cycle
   task automatic step(input obs_t e);
      exp_q.push_back(OBS_W'(e));
      steps++;
      @(posedge clk);
      #1;
   endtask

   task automatic hold_reset(input int n);
      obs_t e;
      for (int i = 0; i < n; i++) begin
         halt_req = hv(1);
         e = base(S_FETCH);
         step(e);
      end
      rst = 1'b1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      ret_m = '0;
      ill_m = 1'b0;
      hold_reset(n);
   endtask

   // One instruction from its FETCH cycle to retirement (or illegal stop).
   // hmode: 0 halt_req low, 1 random, 2 high during the non-FETCH cycles.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic wz,
                            input int waits, input int hmode);
      obs_t e;
      opcode = op; funct = fn; zero = wz; dm_ready = 1'b0; halt_req = 1'b0;
      e = base(S_FETCH); e.ir_we = 1'b1; e.pc_we = 1'b1; e.pc_sel = PC_PLUS1;
      step(e);
      halt_req = hv(hmode);
      e = base(S_DECODE);
      if (op == OP_J || op == OP_JAL || (op == OP_R && fn == FN_JR)) begin
         e.pc_we = 1'b1;
         e.pc_sel = (op == OP_R) ? PC_RS : PC_JUMP;
         e.reg_we = (op == OP_JAL);
         e.link = (op == OP_JAL);
         step(e);
         ret_m = ret_m + 1'b1;
         return;
      end
      step(e);
      if (!is_legal(op)) begin
         ill_m = 1'b1;
         return;
      end
      halt_req = hv(hmode);
      e = base(S_EXEC);
      if (op == OP_R) begin
         e.reg_dst = 1'b1;
         for (int i = 0; i < NFN; i++) if (FN_TAB[i] == fn) e.alu_op = AL_TAB[i];
      end else if (op == OP_BEQ || op == OP_BNE) begin
         e.alu_op = ALU_SUB;
         e.pc_sel = PC_BRANCH;
         e.pc_we = (op == OP_BEQ) ? wz : !wz;
      end else begin
         e.alu_src = 1'b1;
         e.alu_op = ALU_ADD;
      end
      step(e);
      if (op == OP_BEQ || op == OP_BNE) begin
         ret_m = ret_m + 1'b1;
         return;
      end
      if (op == OP_LW || op == OP_SW) begin
         for (int i = 0; i <= waits; i++) begin
            halt_req = hv(hmode);
            dm_ready = (i == waits);
            e = base(S_MEM);
            e.mem_rd = (op == OP_LW);
            e.mem_wr = (op == OP_SW);
            step(e);
         end
         dm_ready = 1'b0;
         if (op == OP_SW) begin
            ret_m = ret_m + 1'b1;
            return;
         end
      end
      halt_req = hv(hmode);
      e = base(S_WB);
      e.reg_we = 1'b1;
      e.mem_to_reg = (op == OP_LW);
      step(e);
      ret_m = ret_m + 1'b1;
   endtask

   // halt_req seen at FETCH, held for 'hold' HALT cycles, then released
   task automatic do_halt(input int hold);
      obs_t e;
      halt_req = 1'b1;
      e = base(S_FETCH);
      step(e);
      for (int i = 0; i < hold; i++) begin
         e = base(S_HALT); e.halted = 1'b1;
         step(e);
      end
      halt_req = 1'b0;
      e = base(S_HALT); e.halted = 1'b1;
      step(e);
   endtask

   // after an illegal opcode: stuck in HALT regardless of halt_req
   task automatic illegal_tail(input int n);
      obs_t e;
      for (int i = 0; i < n; i++) begin
         halt_req = i[0];
         e = base(S_HALT); e.halted = 1'b1;
         step(e);
      end
   endtask

   // SW abandoned by reset in the middle of its memory wait
   task automatic sw_reset_mid_mem();
      obs_t e;
      opcode = OP_SW; funct = '0; halt_req = 1'b0; dm_ready = 1'b0;
      e = base(S_FETCH); e.ir_we = 1'b1; e.pc_we = 1'b1;
      step(e);
      e = base(S_DECODE);
      step(e);
      e = base(S_EXEC); e.alu_src = 1'b1; e.alu_op = ALU_ADD;
      step(e);
      e = base(S_MEM); e.mem_wr = 1'b1;
      exp_q.push_back(OBS_W'(e));
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_mid_mem_wr", {31'd0, mem_wr}, 32'd0);
      chk("rst_mid_mem_state", {29'd0, state}, 32'(S_FETCH));
      chk("rst_mid_mem_retired", 32'(retired), 32'd0);
      ret_m = '0;
      ill_m = 1'b0;
      @(posedge clk);
      #1;
      hold_reset(2);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] op;
      int         k;
      @(posedge clk);
      #1;
      do_reset(3);

      // ADDI then ADD: 4 cycles each, two retirements
      t0 = steps;
      run_instr(OP_ADDI, 6'h00, 1'b0, 0, 0);
      run_instr(OP_R, FN_ADD, 1'b0, 0, 0);
      chk("addi_add_cycles", 32'(steps - t0), 32'd8);
      chk("addi_add_retired", 32'(retired), 32'd2);

      // LW with three wait cycles: 8 cycles total
      t0 = steps;
      run_instr(OP_LW, 6'h00, 1'b0, 3, 0);
      chk("lw_cycles", 32'(steps - t0), 32'd8);
      chk("lw_retired", 32'(retired), 32'd3);

      // SW, branches both ways, jumps
      run_instr(OP_SW, 6'h00, 1'b0, 1, 1);
      t0 = steps;
      run_instr(OP_BNE, 6'h00, 1'b1, 0, 1);
      run_instr(OP_BNE, 6'h00, 1'b0, 0, 1);
      chk("bne_pair_cycles", 32'(steps - t0), 32'd6);
      t0 = steps;
      run_instr(OP_JAL, 6'h00, 1'b0, 0, 1);
      run_instr(OP_R, FN_JR, 1'b0, 0, 1);
      chk("jal_jr_cycles", 32'(steps - t0), 32'd4);
      chk("directed_retired", 32'(retired), 32'd8);

      // illegal opcode: sticky until reset
      run_instr(6'h3F, 6'h00, 1'b0, 0, 1);
      illegal_tail(6);
      chk("illegal_flag", {31'd0, illegal}, 32'd1);
      chk("illegal_halted", {31'd0, halted}, 32'd1);
      chk("illegal_retired", 32'(retired), 32'd8);
      do_reset(2);

      // reset in the middle of a store wait
      run_instr(OP_ADDI, 6'h00, 1'b0, 0, 0);
      sw_reset_mid_mem();

      // counter wrap with a halt requested during a store wait
      for (int i = 0; i < 254; i++) run_instr(OP_R, FN_JR, 1'b0, 0, 1);
      chk("retired_fe", 32'(retired), 32'hFE);
      run_instr(OP_SW, 6'h00, 1'b0, 2, 2);
      chk("retired_ff", 32'(retired), 32'hFF);
      do_halt(3);
      run_instr(OP_J, 6'h00, 1'b0, 0, 0);
      chk("retired_wrap", 32'(retired), 32'h00);

      // randomized instruction stream
      for (int n = 0; n < 400; n++) begin
         k = $urandom_range(0, 19);
         if (k == 0) begin
            do_halt($urandom_range(0, 3));
         end else if (k == 1) begin
            do op = 6'($urandom_range(0, 63)); while (is_legal(op));
            run_instr(op, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 0, 1);
            illegal_tail($urandom_range(1, 4));
            do_reset($urandom_range(1, 3));
         end else begin
            case ($urandom_range(0, 8))
               0: op = OP_ADDI;
               1: op = OP_LW;
               2: op = OP_SW;
               3: op = OP_BEQ;
               4: op = OP_BNE;
               5: op = OP_J;
               6: op = OP_JAL;
               default: op = OP_R;
            endcase
            if (op == OP_R && $urandom_range(0, 4) == 0)
               run_instr(OP_R, FN_JR, 1'($urandom_range(0, 1)), 0, 1);
            else
               run_instr(op, FN_TAB[$urandom_range(0, NFN - 1)], 1'($urandom_range(0, 1)),
                         $urandom_range(0, 4), 1);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
